// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer, free list and map table.
//   ROB_DEPTH / ROB_IDX_W : entry count and index width (power of 2 ring)
//   ROB_CNT_W             : occupancy width, one bit wider so a full ROB is representable
//   PREG_W / AREG_W       : physical / architectural register index widths
//   FL_PTR_W              : free-list head pointer width (snapshotted per entry)
//   rob_entry_t           : one ROB slot
//   rob_offset()          : age of an index relative to head (0 = oldest)
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;
  localparam int ROB_CNT_W = ROB_IDX_W + 1;
  localparam int PREG_W    = 6;
  localparam int AREG_W    = 5;
  localparam int FL_PTR_W  = 5;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic                has_dest;
    logic                is_br;
    logic [AREG_W-1:0]   areg;
    logic [PREG_W-1:0]   new_preg;
    logic [PREG_W-1:0]   old_preg;
    logic [FL_PTR_W-1:0] fl_head;
  } rob_entry_t;

  // Program-order age of idx: wraps naturally in ROB_IDX_W bits.
  function automatic logic [ROB_IDX_W-1:0] rob_offset(
    input logic [ROB_IDX_W-1:0] idx,
    input logic [ROB_IDX_W-1:0] head
  );
    return idx - head;
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer ring.
//   clk, rst        : clock, synchronous active-high reset
//   push_i          : an entry is allocated at tail this cycle
//   pop_i           : the head entry retires this cycle
//   recover_i       : mispredict recovery, truncate ring after recover_idx_i
//   recover_idx_i   : ROB index of the mispredicted branch
//   head_o, tail_o  : current ring pointers
//   full_o, empty_o : occupancy flags
module rob_ptr_ctrl
  import reorder_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 recover_i,
  input  logic [ROB_IDX_W-1:0] recover_idx_i,
  output logic [ROB_IDX_W-1:0] head_o,
  output logic [ROB_IDX_W-1:0] tail_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [ROB_IDX_W-1:0] head_q, head_d;
  logic [ROB_IDX_W-1:0] tail_q, tail_d;
  logic [ROB_CNT_W-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q + ROB_IDX_W'(pop_i);
    tail_d  = tail_q;
    count_d = count_q;
    if (recover_i) begin
      // Survivors are head..branch inclusive; a same-cycle retire still leaves from the front.
      tail_d  = recover_idx_i + ROB_IDX_W'(1);
      count_d = ROB_CNT_W'(rob_offset(recover_idx_i, head_q)) + ROB_CNT_W'(1)
                - ROB_CNT_W'(pop_i);
    end else begin
      tail_d  = tail_q + ROB_IDX_W'(push_i);
      count_d = count_q + ROB_CNT_W'(push_i) - ROB_CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign full_o  = (count_q == ROB_CNT_W'(ROB_DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement ring buffer. Allocates at tail on dispatch, marks entries
// done from the CDB / branch unit, retires the head when done (zero latency), and
// squashes everything younger than a mispredicted branch.
//   clk, rst               : clock, synchronous active-high reset
//   dispatch_*_i           : allocation request and entry payload
//   cdb_vld_i/cdb_rob_idx_i: completion broadcast
//   br_*_i                 : branch resolution and mispredict flag
//   rob_full_o/rob_tail_o  : allocation status and index handed to dispatch
//   retire_*_o             : committed entry; T_old back to the free list
//   recover_en_o/head_o    : free-list/map recovery strobe and head to restore
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dispatch_en_i,
  input  logic                 dispatch_has_dest_i,
  input  logic [AREG_W-1:0]    dispatch_areg_i,
  input  logic [PREG_W-1:0]    dispatch_new_preg_i,
  input  logic [PREG_W-1:0]    dispatch_old_preg_i,
  input  logic                 dispatch_is_br_i,
  input  logic [FL_PTR_W-1:0]  dispatch_fl_head_i,
  input  logic                 cdb_vld_i,
  input  logic [ROB_IDX_W-1:0] cdb_rob_idx_i,
  input  logic                 br_resolve_en_i,
  input  logic [ROB_IDX_W-1:0] br_rob_idx_i,
  input  logic                 br_mispredict_i,
  output logic                 rob_full_o,
  output logic [ROB_IDX_W-1:0] rob_tail_o,
  output logic                 retire_en_o,
  output logic                 retire_fl_en_o,
  output logic [PREG_W-1:0]    retire_preg_o,
  output logic [AREG_W-1:0]    retire_areg_o,
  output logic [PREG_W-1:0]    retire_new_preg_o,
  output logic                 recover_en_o,
  output logic [FL_PTR_W-1:0]  recover_head_o
);

  rob_entry_t rob_q [ROB_DEPTH];
  rob_entry_t rob_d [ROB_DEPTH];

  logic [ROB_IDX_W-1:0] head;
  logic [ROB_IDX_W-1:0] tail;
  logic                 full;
  logic                 empty;
  logic                 dispatch_ok;
  logic                 retire_en;
  logic                 recover_en;

  assign recover_en  = br_resolve_en_i & br_mispredict_i;
  assign retire_en   = ~empty & rob_q[head].valid & rob_q[head].done;
  assign dispatch_ok = dispatch_en_i & ~full & ~recover_en;

  rob_ptr_ctrl u_ptr (
    .clk           (clk),
    .rst           (rst),
    .push_i        (dispatch_ok),
    .pop_i         (retire_en),
    .recover_i     (recover_en),
    .recover_idx_i (br_rob_idx_i),
    .head_o        (head),
    .tail_o        (tail),
    .full_o        (full),
    .empty_o       (empty)
  );

  // Order matters: completions first, then squash (so a CDB hit on a squashed
  // slot is lost), then retire, then allocation into a slot known to be free.
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) rob_d[i] = rob_q[i];

    if (cdb_vld_i && rob_q[cdb_rob_idx_i].valid) rob_d[cdb_rob_idx_i].done = 1'b1;
    if (br_resolve_en_i && rob_q[br_rob_idx_i].valid) rob_d[br_rob_idx_i].done = 1'b1;

    if (recover_en) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (rob_offset(ROB_IDX_W'(i), head) > rob_offset(br_rob_idx_i, head)) begin
          rob_d[i].valid = 1'b0;
          rob_d[i].done  = 1'b0;
        end
      end
    end

    if (retire_en) begin
      rob_d[head].valid = 1'b0;
      rob_d[head].done  = 1'b0;
    end

    if (dispatch_ok) begin
      rob_d[tail].valid    = 1'b1;
      rob_d[tail].done     = 1'b0;
      rob_d[tail].has_dest = dispatch_has_dest_i;
      rob_d[tail].is_br    = dispatch_is_br_i;
      rob_d[tail].areg     = dispatch_areg_i;
      rob_d[tail].new_preg = dispatch_new_preg_i;
      rob_d[tail].old_preg = dispatch_old_preg_i;
      rob_d[tail].fl_head  = dispatch_fl_head_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
    end else begin
      rob_q <= rob_d;
    end
  end

  assign rob_full_o        = full;
  assign rob_tail_o        = tail;
  assign retire_en_o       = retire_en;
  assign retire_fl_en_o    = retire_en & rob_q[head].has_dest;
  assign retire_preg_o     = retire_en ? rob_q[head].old_preg : '0;
  assign retire_areg_o     = retire_en ? rob_q[head].areg : '0;
  assign retire_new_preg_o = retire_en ? rob_q[head].new_preg : '0;
  assign recover_en_o      = recover_en;
  assign recover_head_o    = recover_en ? rob_q[br_rob_idx_i].fl_head : '0;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement ring buffer of the R10K pipeline.
- Allocates one entry per dispatched instruction, collects completion from CDB/branch unit, retires one entry per cycle in program order.
- Retire side feeds the free list: returns the previous physical register (T_old) and drives single-cycle branch recovery of the free-list head.

Parameters:
ROB_DEPTH, 16, entry count; power of 2
ROB_IDX_W, 4, log2(ROB_DEPTH)
PREG_W, 6, physical register index width
AREG_W, 5, architectural register index width
FL_PTR_W, 5, free-list head pointer width

Ports:
clk  in  1  clock
rst  in  1  reset
dispatch_en_i  in  1  allocate entry this cycle
dispatch_has_dest_i  in  1  instruction writes a register
dispatch_areg_i  in  AREG_W  destination arch reg
dispatch_new_preg_i  in  PREG_W  T from free list
dispatch_old_preg_i  in  PREG_W  T_old from map table
dispatch_is_br_i  in  1  instruction is a branch (never has_dest)
dispatch_fl_head_i  in  FL_PTR_W  free-list head snapshot
cdb_vld_i  in  1  completion broadcast valid
cdb_rob_idx_i  in  ROB_IDX_W  completing entry
br_resolve_en_i  in  1  branch resolved this cycle
br_rob_idx_i  in  ROB_IDX_W  resolving branch entry
br_mispredict_i  in  1  resolved branch mispredicted
rob_full_o  out  1  no free entry
rob_tail_o  out  ROB_IDX_W  index assigned to current dispatch
retire_en_o  out  1  head entry retires this cycle
retire_fl_en_o  out  1  free-list write enable (retire_en_o & has_dest)
retire_preg_o  out  PREG_W  T_old returned to free list
retire_areg_o  out  AREG_W  arch reg committed
retire_new_preg_o  out  PREG_W  T committed to arch map
recover_en_o  out  1  free-list/map recovery strobe
recover_head_o  out  FL_PTR_W  free-list head to restore

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. head=tail=count=0, all valid/done bits 0. rob_full_o=0, rob_tail_o=0; all retire_*/recover_* outputs 0.
- Per-entry state: valid, done, has_dest, is_br, areg, new_preg, old_preg, fl_head.
- Outputs are combinational from registered state plus same-cycle br inputs; zero-latency retire.
- rob_full_o = (count == ROB_DEPTH). rob_tail_o = tail.
- Dispatch accepted iff dispatch_en_i & ~rob_full_o & ~recover_en_o. Entry written at tail with done=0; tail++ mod ROB_DEPTH.
- Dispatch while full is dropped; no overwrite. No same-cycle bypass of a freed slot.
- Completion: cdb_vld_i sets done[cdb_rob_idx_i]; br_resolve_en_i sets done[br_rob_idx_i]. Writes to invalid entries are ignored.
- Retire: retire_en_o = (count != 0) & done[head]. Entry invalidated; head++ mod ROB_DEPTH. Retire fields come from the head entry. retire_fl_en_o is 0 for no-dest entries.
- Recovery:
  - recover_en_o = br_resolve_en_i & br_mispredict_i.
  - recover_head_o = fl_head[br_rob_idx_i]; otherwise 0.
  - At the clock edge, entries younger than the branch are invalidated and tail <= br_rob_idx_i+1.
  - count <= ((br_rob_idx_i - head) mod ROB_DEPTH) + 1 - retire_en_o.
  - The branch itself stays valid and is marked done.
- Simultaneous events:
  - Recover + dispatch: dispatch dropped.
  - Recover + retire of an older head: retire proceeds.
  - CDB to a squashed index in the recovery cycle: no effect.
  - Dispatch + retire: count unchanged.
  - Dispatch + retire when count==ROB_DEPTH: only retire occurs.
- Wrap-around: all pointer arithmetic is mod ROB_DEPTH. Index comparisons use offset from head, not raw index order.
- rst mid-operation discards all entries; outputs return to reset values next cycle.

Decomposition:
- Shared package:
  - rob_entry_t struct (valid, done, has_dest, is_br, areg, new_preg, old_preg, fl_head).
  - ROB_DEPTH, PREG_W, AREG_W, FL_PTR_W constants, also used by the free list and map table.
- One natural sub-module, rob_ptr_ctrl: head/tail/count update logic including recovery count arithmetic. The entry array stays in the top.

Test Plan:
- Reset, then dispatch 3 (areg 1/2/3, new 33/34/35, old 1/2/3); CDB idx 1 then 0 -> idx0 retires with retire_preg_o=1, retire_fl_en_o=1; next cycle idx1 retires with retire_preg_o=2; idx2 holds.
- Dispatch 16 entries -> rob_full_o=1, 17th dispatch ignored, rob_tail_o=0; complete idx0 -> retire_en_o=1, next cycle rob_full_o=0.
- Dispatch branch at idx 2 with fl_head=7, then idx 3-5; br_resolve idx2 mispredict -> recover_en_o=1 and recover_head_o=7 same cycle; next cycle count=3, rob_tail_o=3.
- Mispredict in the same cycle as dispatch_en_i=1 -> dispatch dropped, tail = branch+1.
- Advance pointers to head=14; dispatch 4 entries (wrap to idx 1); complete in reverse order -> retirement order 14, 15, 0, 1.
- Retire an entry with dispatch_has_dest_i=0 -> retire_en_o=1, retire_fl_en_o=0.
